// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory behind a req/ready handshake.
// A request is accepted in IDLE, held for WAIT_CYCLES wait states in BUSY,
// then completed on the edge entering DONE, which lasts exactly one cycle.
// Out-of-range addresses suppress the write, return zero on a read and
// raise err together with the ready pulse.
//
// Ports:
//   clk       - clock; all state changes on the rising edge
//   reset     - synchronous, active-low reset (memory array is not cleared)
//   req       - access request level, sampled only in IDLE
//   we        - 1 = write, 0 = read (sampled with req)
//   addr      - 32-bit word address (sampled with req)
//   wdata     - store data (sampled with req)
//   rdata     - registered read data, held until the next completed read
//   ready     - one-cycle completion pulse
//   err       - out-of-range flag, pulses together with ready
//   busy      - high in BUSY and DONE
//   dbg_addr  - debug read index
//   dbg_data  - combinational mem[dbg_addr]
module dmem_responder #(
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  ready,
  output logic                  err,
  output logic                  busy,
  input  logic [DEPTH_LOG2-1:0] dbg_addr,
  output logic [31:0]           dbg_data
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;

  logic [31:0]           mem [2**DEPTH_LOG2];

  // Access operands: taken straight from the inputs when the access happens
  // on the accept edge itself (zero wait states), otherwise from the latches.
  logic                  do_access;
  logic                  acc_we;
  logic [31:0]           acc_addr;
  logic [31:0]           acc_wdata;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic                  mem_wr;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    do_access = 1'b0;
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d      = we;
          addr_d    = addr;
          wdata_d   = wdata;
          acc_we    = we;
          acc_addr  = addr;
          acc_wdata = wdata;
          if (WAIT_CYCLES == 0) begin
            do_access = 1'b1;
            state_d   = S_DONE;
          end else begin
            cnt_d   = 4'(WAIT_CYCLES);
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd1) begin
          do_access = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    in_range = (acc_addr >> DEPTH_LOG2) == 32'd0;
    acc_idx  = acc_addr[DEPTH_LOG2-1:0];
    mem_wr   = do_access && acc_we && in_range;

    if (do_access) begin
      ready_d = 1'b1;
      err_d   = !in_range;
      if (!acc_we) begin
        rdata_d = in_range ? mem[acc_idx] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Memory has no reset; reset only blocks a write that would otherwise
  // commit on the same edge.
  always_ff @(posedge clk) begin
    if (reset && mem_wr) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  assign rdata    = rdata_q;
  assign ready    = ready_q;
  assign err      = err_q;
  assign busy     = (state_q != S_IDLE);
  assign dbg_data = mem[dbg_addr];

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: a WAIT_CYCLES=2 instance exercised with
// directed and random transactions against a word-array reference model,
// plus a WAIT_CYCLES=0 instance for the zero-wait-state timing.
module tb_dmem_responder;

  localparam int unsigned W = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [31:0] addr, wdata, rdata;
  logic        ready, err, busy;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_data;

  logic        z_req, z_we;
  logic [31:0] z_addr, z_wdata, z_rdata;
  logic        z_ready, z_err, z_busy;
  logic [7:0]  z_dbg_addr;
  logic [31:0] z_dbg_data;

  int checks = 0;
  int errors = 0;

  // Reference model: word array with per-word validity, plus last read data.
  logic [31:0] ref_mem [256];
  bit          known   [256];
  logic [31:0] rd_model;
  bit          rd_valid;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .err(err), .busy(busy),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  dmem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .req(z_req), .we(z_we), .addr(z_addr), .wdata(z_wdata),
    .rdata(z_rdata), .ready(z_ready), .err(z_err), .busy(z_busy),
    .dbg_addr(z_dbg_addr), .dbg_data(z_dbg_data)
  );

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    checks++; if (z_busy !== 1'b0 || z_ready !== 1'b0) begin errors++; $display("FAIL reset_z got busy=%b ready=%b exp=0,0", z_busy, z_ready); end
    reset    = 1'b1;
    rd_model = 32'h0;
    rd_valid = 1'b1;
  endtask

  // One complete transaction starting and ending in IDLE. After acceptance
  // the inputs are driven to (ca, cd, random we) to show they are ignored.
  task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] ca, input logic [31:0] cd, input string tag);
    int unsigned n;
    bit          inr;
    int unsigned idx;
    logic [31:0] dbg_before;
    logic [31:0] old_word;
    bit          old_known;
    inr       = (a < 32'd256);
    idx       = a % 256;
    old_word  = ref_mem[idx];
    old_known = known[idx];
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; we = 1'($urandom); addr = ca; wdata = cd;
    dbg_addr = 8'(idx);
    #1;
    dbg_before = dbg_data;
    n = 0;
    while (!ready && n < 20) begin
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL %s err_while_busy got=%b exp=0", tag, err); end
      dbg_before = dbg_data;
      @(negedge clk);
      n++;
    end
    // model update
    if (w && inr) begin ref_mem[idx] = d; known[idx] = 1'b1; end
    if (!w) begin
      if (!inr) begin rd_model = 32'h0; rd_valid = 1'b1; end
      else begin rd_model = old_word; rd_valid = old_known; end
    end
    checks++; if (ready !== 1'b1 || n != W) begin errors++; $display("FAIL %s latency got ready=%b after %0d cycles exp=1 after %0d", tag, ready, n, W); end
    checks++; if (err !== !inr) begin errors++; $display("FAIL %s err got=%b exp=%b", tag, err, !inr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_done got=%b exp=1", tag, busy); end
    if (rd_valid) begin
      checks++; if (rdata !== rd_model) begin errors++; $display("FAIL %s rdata got=%h exp=%h", tag, rdata, rd_model); end
    end
    if (w && inr && old_known) begin
      checks++; if (dbg_before !== old_word) begin errors++; $display("FAIL %s dbg_before_commit got=%h exp=%h", tag, dbg_before, old_word); end
    end
    @(negedge clk);
    checks++; if (ready !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s after_done got ready=%b err=%b busy=%b exp=0,0,0", tag, ready, err, busy); end
    if (known[idx]) begin
      checks++; if (dbg_data !== ref_mem[idx]) begin errors++; $display("FAIL %s dbg_after got=%h exp=%h", tag, dbg_data, ref_mem[idx]); end
    end
  endtask

  task automatic test_write_read();
    access(1'b1, 32'd5, 32'hDEADBEEF, 32'd6, 32'h0BADF00D, "wr5");
    access(1'b0, 32'd5, 32'h0, 32'd6, 32'h0, "rd5");
  endtask

  task automatic test_out_of_range();
    access(1'b1, 32'd0, 32'h0000_0777, 32'd0, 32'h0, "pre0");
    access(1'b1, 32'h100, 32'h1234, 32'd0, 32'h0, "oor_wr");
    access(1'b0, 32'd0, 32'h0, 32'd0, 32'h0, "rd0_after_oor");
    access(1'b0, 32'h100, 32'h0, 32'd0, 32'h0, "oor_rd");
    access(1'b0, 32'd5, 32'h0, 32'd0, 32'h0, "rd5_again");
    access(1'b0, 32'h8000_0000, 32'h0, 32'd5, 32'h0, "oor_rd_top");
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] old7;
    access(1'b1, 32'd7, 32'h1357_9BDF, 32'd0, 32'h0, "pre7");
    access(1'b0, 32'd7, 32'h0, 32'd0, 32'h0, "rd7");
    old7 = ref_mem[7];
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'd7; wdata = 32'hA5A5A5A5;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL rst_mid busy_ready got busy=%b ready=%b exp=0,0", busy, ready); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_mid rdata got=%h exp=0", rdata); end
    reset = 1'b1;
    rd_model = 32'h0;
    rd_valid = 1'b1;
    dbg_addr = 8'd7;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_mid late_ready got=%b exp=0", ready); end
    end
    checks++; if (dbg_data !== old7) begin errors++; $display("FAIL rst_mid mem7 got=%h exp=%h", dbg_data, old7); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] seq [3];
    bit exp_rdy;
    access(1'b1, 32'd1, 32'd11, 32'd0, 32'h0, "pre1");
    access(1'b1, 32'd2, 32'd22, 32'd0, 32'h0, "pre2");
    access(1'b1, 32'd3, 32'd33, 32'd0, 32'h0, "pre3");
    seq[0] = ref_mem[1]; seq[1] = ref_mem[2]; seq[2] = ref_mem[3];
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'd1;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk);
      @(negedge clk);
      exp_rdy = (e == 2 || e == 6 || e == 10);
      checks++; if (ready !== exp_rdy) begin errors++; $display("FAIL b2b ready_edge%0d got=%b exp=%b", e, ready, exp_rdy); end
      if (exp_rdy) begin
        checks++; if (rdata !== seq[e/4]) begin errors++; $display("FAIL b2b rdata_edge%0d got=%h exp=%h", e, rdata, seq[e/4]); end
      end
      if (e == 0) addr = 32'd2;
      if (e == 4) addr = 32'd3;
      if (e == 8) req = 1'b0;
    end
    rd_model = seq[2];
    rd_valid = 1'b1;
  endtask

  task automatic test_zero_wait();
    logic [31:0] v;
    v = $urandom;
    @(negedge clk);
    z_req = 1'b1; z_we = 1'b1; z_addr = 32'd9; z_wdata = v; z_dbg_addr = 8'd9;
    @(posedge clk);
    @(negedge clk);
    checks++; if (z_ready !== 1'b1 || z_err !== 1'b0 || z_busy !== 1'b1) begin errors++; $display("FAIL zw wr_done got ready=%b err=%b busy=%b exp=1,0,1", z_ready, z_err, z_busy); end
    z_we = 1'b0; z_wdata = ~v;
    @(posedge clk);
    @(negedge clk);
    checks++; if (z_ready !== 1'b0 || z_busy !== 1'b0) begin errors++; $display("FAIL zw idle got ready=%b busy=%b exp=0,0", z_ready, z_busy); end
    checks++; if (z_dbg_data !== v) begin errors++; $display("FAIL zw dbg9 got=%h exp=%h", z_dbg_data, v); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (z_ready !== 1'b1 || z_rdata !== v) begin errors++; $display("FAIL zw rd got ready=%b rdata=%h exp=1,%h", z_ready, z_rdata, v); end
    z_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (z_ready !== 1'b0 || z_busy !== 1'b0) begin errors++; $display("FAIL zw end got ready=%b busy=%b exp=0,0", z_ready, z_busy); end
  endtask

  task automatic test_input_change();
    access(1'b1, 32'd4, 32'h4444_4444, 32'd0, 32'h0, "pre4");
    access(1'b1, 32'd3, 32'hC0DE_0003, 32'd4, 32'hFFFF_0000, "chg_wr3");
    dbg_addr = 8'd4;
    #1;
    checks++; if (dbg_data !== 32'h4444_4444) begin errors++; $display("FAIL chg mem4 got=%h exp=44444444", dbg_data); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 16; i++)
      access(1'b1, 32'(i), $urandom, $urandom, $urandom, "rnd_pre");
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) a = 32'd256 + $urandom_range(0, 100000);
      else a = $urandom_range(0, 15);
      access(1'($urandom), a, $urandom, $urandom, $urandom, "rnd");
    end
  endtask

  initial begin
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; dbg_addr = '0;
    z_req = 1'b0; z_we = 1'b0; z_addr = '0; z_wdata = '0; z_dbg_addr = '0;
    for (int i = 0; i < 256; i++) begin ref_mem[i] = '0; known[i] = 1'b0; end
    rd_model = '0;
    rd_valid = 1'b0;
    test_reset();
    test_write_read();
    test_out_of_range();
    test_reset_mid_access();
    test_back_to_back();
    test_zero_wait();
    test_input_change();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder serving the load/store side of the multi-cycle CPU core. The core initiates a word access with a request level; this block acknowledges it after a configurable number of wait states. Writes are committed to an internal word array, and read data is returned in a register. The CPU stalls on `busy`/`ready`. A combinational debug read port lets benches inspect memory contents.

Parameters:
- DEPTH_LOG2, 8: log2 of the number of 32-bit words; array holds 2^DEPTH_LOG2 words.
- WAIT_CYCLES, 2: wait states between acceptance and completion; legal range 0..15.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- reset, input, 1: synchronous, active-low reset.
- req, input, 1: access request level from the CPU.
- we, input, 1: 1 = write, 0 = read; sampled with req.
- addr, input, 32: word address; not a byte address.
- wdata, input, 32: store data; sampled with req.
- rdata, output, 32: registered read data.
- ready, output, 1: one-cycle completion pulse.
- err, output, 1: out-of-range flag; pulses together with ready.
- busy, output, 1: high whenever the state is not IDLE.
- dbg_addr, input, DEPTH_LOG2: debug read index.
- dbg_data, output, 32: combinational mem[dbg_addr].

Behaviour:
- **Reset:** reset=0 at a rising edge sets state=IDLE, cnt=0, ready=0, err=0, rdata=0, and clears latched request registers.
  - Memory array is not cleared.
  - Reset has priority over every other event.
  - Reset during BUSY aborts the access: no write, no ready pulse.
- **States:** IDLE, BUSY, DONE.
- **IDLE:**
  - If req=1 at the edge, the request is accepted: addr, we and wdata are latched.
  - If WAIT_CYCLES=0, go to DONE at this edge and perform the access.
  - Otherwise load cnt=WAIT_CYCLES and go to BUSY.
  - If req=0, stay in IDLE.
- **BUSY:**
  - Each edge: if cnt==1, perform the access and go to DONE; else cnt<=cnt-1.
  - Changes on req, we, addr or wdata are ignored; the latched values are used.
- **Access (at the edge entering DONE):**
  - In range (latched addr[31:DEPTH_LOG2]==0):
    - write: mem[addr] <= wdata; rdata unchanged.
    - read: rdata <= mem[addr].
    - err<=0.
  - Out of range:
    - write is suppressed.
    - a read sets rdata <= 0.
    - err<=1.
  - ready<=1 in both cases.
- **DONE:**
  - Lasts exactly one cycle; goes to IDLE unconditionally.
  - ready and err clear at the edge leaving DONE.
  - req is not sampled in DONE.
- **Latency:**
  - Accepted at edge k, so ready is high in the cycle after edge k+WAIT_CYCLES.
  - With req held high, transactions repeat every WAIT_CYCLES+2 cycles.
- **rdata** holds its value until the next completed read or reset.
- **busy** is 1 in BUSY and DONE; it is 0 in IDLE, including the accept edge's preceding cycle.
- **dbg_data** reflects writes from the edge after commit; a same-address debug read during the commit cycle returns the old value.
- **Addressing:** index = addr[DEPTH_LOG2-1:0]; no wrap-around aliasing, because out-of-range addresses flag err.

Test Plan:
1. Write then read, WAIT_CYCLES=2.
   - Stimulus: req=1, we=1, addr=5, wdata=32'hDEADBEEF accepted at edge 0.
   - Response: ready=1 only after edge 2; dbg_addr=5 gives 32'hDEADBEEF after edge 3.
   - Stimulus: a read of addr=5 accepted at edge 4.
   - Response: rdata=32'hDEADBEEF and ready=1 after edge 6; err=0 throughout.
2. Out-of-range access.
   - Stimulus: write addr=32'h100, wdata=32'h1234.
   - Response: ready=err=1 in the same cycle; mem[0] unchanged.
   - Stimulus: read addr=32'h100.
   - Response: rdata=0, err=1.
3. Reset mid-access.
   - Stimulus: write addr=7, wdata=32'hA5A5A5A5 accepted at edge 0; reset=0 at edge 1.
   - Response: no ready pulse; busy=0 after edge 1; mem[7] keeps its prior value; rdata=0.
4. Back-to-back requests.
   - Stimulus: req held high with reads of addr 1, 2, 3 (pre-loaded 11, 22, 33).
   - Response: ready pulses after edges 2, 6, 10; rdata sequence 11, 22, 33.
5. Zero wait states, WAIT_CYCLES=0.
   - Stimulus: write addr=9 accepted at edge 0.
   - Response: ready after edge 0; next acceptance at edge 2; read returns the written value after edge 2.
6. Input change during BUSY.
   - Stimulus: a write to addr 3 accepted; addr switched to 4 and wdata changed at edge 1.
   - Response: mem[3] receives the originally latched wdata; mem[4] unchanged.
